// File: rtl/gearbox_ser2par_pkg.sv
// Shared constants and helpers for the gearbox, divider wrapper and framer.
package gearbox_ser2par_pkg;

  localparam int unsigned RATIO_MIN = 2;
  localparam int unsigned RATIO_MAX = 8;

  // Ceiling log2 usable in constant expressions (returns 0 for v <= 1).
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gearbox_ser2par_slip_ctl.sv
// Slip request handling: rising-edge detect, single pending flag, ack pulse.
module gearbox_ser2par_slip_ctl (
  input  logic clk,
  input  logic rst_n,
  input  logic slip,
  input  logic in_valid,
  output logic slip_pend,
  output logic slip_ack
);

  logic slip_q;
  logic drop_c;

  // A pending slip swallows the next valid sample.
  assign drop_c = slip_pend & in_valid;

  // Edge register, pending flag (no queueing) and one-cycle ack after a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_q    <= 1'b0;
      slip_pend <= 1'b0;
      slip_ack  <= 1'b0;
    end else begin
      slip_q   <= slip;
      slip_ack <= drop_c;
      if (drop_c) begin
        slip_pend <= 1'b0;
      end else if (slip && !slip_q) begin
        slip_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gearbox_ser2par.sv
// Fast-domain serial-to-parallel gearbox: packs RATIO valid samples per word
// and holds each word until the next one completes.
module gearbox_ser2par
  import gearbox_ser2par_pkg::*;
#(
  parameter int unsigned DATA_W    = 2,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                            in_clk,
  input  logic                            rst_n,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  input  logic                            slip,
  output logic [DATA_W*RATIO-1:0]         out_data,
  output logic                            out_valid,
  output logic                            slip_ack,
  output logic [clog2_f(RATIO)-1:0]       fill_cnt
);

  localparam int unsigned WORD_W = DATA_W * RATIO;
  localparam int unsigned CNT_W  = clog2_f(RATIO);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

  // Ratio must match what the downstream divider supports.
  if ((RATIO < RATIO_MIN) || (RATIO > RATIO_MAX)) begin : g_ratio_chk
    $error("gearbox_ser2par: RATIO must be within 2..8");
  end

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_c;
  logic              slip_pend;
  logic              accept_c;

  gearbox_ser2par_slip_ctl u_slip_ctl (
    .clk       (in_clk),
    .rst_n     (rst_n),
    .slip      (slip),
    .in_valid  (in_valid),
    .slip_pend (slip_pend),
    .slip_ack  (slip_ack)
  );

  // Samples arriving while a slip is pending are dropped, not accepted.
  assign accept_c = in_valid & ~slip_pend;

  // Assembly word with the current sample merged into slot cnt.
  always_comb begin
    int unsigned base;
    asm_c = asm_q;
    base  = 0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      base = MSB_FIRST ? (RATIO - 1 - k) * DATA_W : k * DATA_W;
      if (cnt == CNT_W'(k)) begin
        asm_c[base +: DATA_W] = in_data;
      end
    end
  end

  // Slot counter, assembly register and word hand-off.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      asm_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept_c) begin
        asm_q <= asm_c;
        if (cnt == LAST_SLOT) begin
          out_data  <= asm_c;
          out_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign fill_cnt = cnt;

endmodule

// File: tb/tb_gearbox_ser2par.sv
// Directed bench for gearbox_ser2par: MSB-first and LSB-first instances share stimulus.
module tb_gearbox_ser2par;

  logic       in_clk;
  logic       rst_n;
  logic [1:0] in_data;
  logic       in_valid;
  logic       slip;

  logic [7:0] out_data_m, out_data_l;
  logic       out_valid_m, out_valid_l;
  logic       slip_ack_m, slip_ack_l;
  logic [1:0] fill_cnt_m, fill_cnt_l;

  int n_checks = 0;
  int n_fail   = 0;
  int vec_id   = 0;

  logic [7:0] em;
  logic [7:0] el;

  logic [1:0] sh_d   [13] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
  int         sh_f   [13] = '{1, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
  logic       sh_ov  [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  logic       sh_ack [13] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [7:0] sh_m   [13] = '{8'h93, 8'h93, 8'h93, 8'h93, 8'h8E, 8'h8E, 8'h8E, 8'h8E,
                              8'h4E, 8'h4E, 8'h4E, 8'h4E, 8'h4E};
  logic [7:0] sh_l   [13] = '{8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hB2, 8'hB2, 8'hB2, 8'hB2,
                              8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1};

  gearbox_ser2par #(.DATA_W(2), .RATIO(4), .MSB_FIRST(1'b1)) dut_msb (
    .in_clk    (in_clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .slip      (slip),
    .out_data  (out_data_m),
    .out_valid (out_valid_m),
    .slip_ack  (slip_ack_m),
    .fill_cnt  (fill_cnt_m)
  );

  gearbox_ser2par #(.DATA_W(2), .RATIO(4), .MSB_FIRST(1'b0)) dut_lsb (
    .in_clk    (in_clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .slip      (slip),
    .out_data  (out_data_l),
    .out_valid (out_valid_l),
    .slip_ack  (slip_ack_l),
    .fill_cnt  (fill_cnt_l)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", tag, vec_id, got, exp);
    end
  endtask

  // Apply one input vector for one clock and check the registered response.
  task automatic vec(input logic v, input logic [1:0] d, input logic s,
                     input int fill, input logic ov, input logic ack,
                     input logic [7:0] m, input logic [7:0] l);
    in_valid = v;
    in_data  = d;
    slip     = s;
    @(posedge in_clk);
    @(negedge in_clk);
    vec_id++;
    check("fill_cnt", 32'(fill_cnt_m), 32'(fill));
    check("out_valid", 32'(out_valid_m), 32'(ov));
    check("out_valid_lsb", 32'(out_valid_l), 32'(ov));
    check("slip_ack", 32'(slip_ack_m), 32'(ack));
    check("out_data_msb", 32'(out_data_m), 32'(m));
    check("out_data_lsb", 32'(out_data_l), 32'(l));
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = 2'd0;
    slip     = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge in_clk);

    // Reset state
    check("rst_out_data", 32'(out_data_m), 32'h0);
    check("rst_out_valid", 32'(out_valid_m), 32'h0);
    check("rst_slip_ack", 32'(slip_ack_m), 32'h0);
    check("rst_fill_cnt", 32'(fill_cnt_m), 32'h0);
    check("rst_out_data_lsb", 32'(out_data_l), 32'h0);
    rst_n = 1'b1;

    // Partial word 1,2,3 then asynchronous reset mid-cycle
    vec(1'b1, 2'd1, 1'b0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    vec(1'b1, 2'd2, 1'b0, 2, 1'b0, 1'b0, 8'h00, 8'h00);
    vec(1'b1, 2'd3, 1'b0, 3, 1'b0, 1'b0, 8'h00, 8'h00);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_fill", 32'(fill_cnt_m), 32'h0);
    check("async_rst_fill_lsb", 32'(fill_cnt_l), 32'h0);
    @(negedge in_clk);
    rst_n = 1'b1;

    // Fresh word 0,1,2,3 after reset
    vec(1'b1, 2'd0, 1'b0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    vec(1'b1, 2'd1, 1'b0, 2, 1'b0, 1'b0, 8'h00, 8'h00);
    vec(1'b1, 2'd2, 1'b0, 3, 1'b0, 1'b0, 8'h00, 8'h00);
    vec(1'b1, 2'd3, 1'b0, 0, 1'b1, 1'b0, 8'h1B, 8'hE4);
    vec(1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b0, 8'h1B, 8'hE4);

    // Continuous 3,2,1,0 stream: E4 (MSB first) / 1B (LSB first) every 4 cycles
    em = 8'h1B;
    el = 8'hE4;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) begin
          em = 8'hE4;
          el = 8'h1B;
        end
        vec(1'b1, 2'(3 - i), 1'b0, (i + 1) % 4, i == 3, 1'b0, em, el);
      end
    end

    // Gapped input: each sample followed by 3 idle cycles carrying junk data
    for (int i = 0; i < 4; i++) begin
      vec(1'b1, 2'(3 - i), 1'b0, (i + 1) % 4, i == 3, 1'b0, 8'hE4, 8'h1B);
      for (int g = 0; g < 3; g++) begin
        vec(1'b0, 2'(g), 1'b0, (i + 1) % 4, 1'b0, 1'b0, 8'hE4, 8'h1B);
      end
    end

    // Single slip pulse: sample 3 dropped, boundary moves to 2,1,0,3
    vec(1'b0, 2'd0, 1'b1, 0, 1'b0, 1'b0, 8'hE4, 8'h1B);
    vec(1'b1, 2'd3, 1'b0, 0, 1'b0, 1'b1, 8'hE4, 8'h1B);
    vec(1'b1, 2'd2, 1'b0, 1, 1'b0, 1'b0, 8'hE4, 8'h1B);
    vec(1'b1, 2'd1, 1'b0, 2, 1'b0, 1'b0, 8'hE4, 8'h1B);
    vec(1'b1, 2'd0, 1'b0, 3, 1'b0, 1'b0, 8'hE4, 8'h1B);
    vec(1'b1, 2'd3, 1'b0, 0, 1'b1, 1'b0, 8'h93, 8'hC6);
    vec(1'b1, 2'd2, 1'b0, 1, 1'b0, 1'b0, 8'h93, 8'hC6);
    vec(1'b1, 2'd1, 1'b0, 2, 1'b0, 1'b0, 8'h93, 8'hC6);
    vec(1'b1, 2'd0, 1'b0, 3, 1'b0, 1'b0, 8'h93, 8'hC6);
    vec(1'b1, 2'd3, 1'b0, 0, 1'b1, 1'b0, 8'h93, 8'hC6);

    // Slip held 10 cycles, rising with a valid sample: that sample kept, next dropped, once
    for (int i = 0; i < 13; i++) begin
      vec(1'b1, sh_d[i], i < 10, sh_f[i], sh_ov[i], sh_ack[i], sh_m[i], sh_l[i]);
    end

    // Idle tail: outputs hold
    vec(1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b0, 8'h4E, 8'hB1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gearbox_ser2par.md
Name: gearbox_ser2par

Overview:
- Fast-domain serial-to-parallel gearbox. Sits directly upstream of the clock divider stage.
- Runs on the undivided clock and packs RATIO consecutive valid samples into one word.
- Holds each word stable for at least RATIO cycles, so the divided-clock domain (in_clk / RATIO) can capture it.
- Provides a slip control so downstream framing logic can shift the word boundary by one sample.

Parameters:
- DATA_W, 2, bits per input sample (e.g. one I/Q dibit).
- RATIO, 4, samples per output word; legal range 2..8, matching the divider's ratio.
- MSB_FIRST, 1, 1 = first received sample lands in the most-significant slot of out_data; 0 = least-significant slot.

Ports:
- in_clk  input  1  fast clock; also the divider's input clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  sample.
- in_valid  input  1  sample qualifier; may be deasserted on any cycle.
- slip  input  1  request to drop one sample (level or pulse, edge-detected).
- out_data  output  DATA_W*RATIO  assembled word.
- out_valid  output  1  one-cycle pulse: new word loaded into out_data.
- slip_ack  output  1  one-cycle pulse: a sample was dropped.
- fill_cnt  output  $clog2(RATIO)  slots filled in the word currently being assembled (debug / alignment).

Behaviour:
- Reset: while rst_n = 0, all outputs and internal state clear immediately and asynchronously: out_data = 0, out_valid = 0, slip_ack = 0, fill_cnt = 0, slip_pend = 0, slip edge register = 0. Operation resumes on the first in_clk edge after deassertion. A partial word is discarded.
- Slot counter: cnt runs 0..RATIO-1 and is advanced only by accepted samples. An accepted sample is in_valid = 1 and no slip pending.
- Slot position: accepted sample k of a word goes to slot k.
  - MSB_FIRST = 1: slot k = bits [(RATIO-k)*DATA_W-1 -: DATA_W].
  - MSB_FIRST = 0: slot k = bits [(k+1)*DATA_W-1 -: DATA_W].
- Word completion: an accepted sample with cnt = RATIO-1 completes the word. On the next edge:
  - out_data <= the full word, including this sample;
  - out_valid = 1 for exactly one cycle;
  - cnt <= 0.
  - Latency: out_valid rises one cycle after the RATIO-th sample is presented.
- Hold: out_data changes only on word completion; it otherwise holds its value indefinitely.
- Gaps: in_valid = 0 freezes cnt and the assembly register. A gap of any length never emits a partial word.
- Slip request: a rising edge of slip (against the registered previous value) sets slip_pend. Further edges while slip_pend = 1 are ignored; there is no queueing.
- Slip consumption: the next cycle with in_valid = 1 while slip_pend = 1 drops that sample. On that cycle:
  - cnt and the assembly register are unchanged;
  - slip_pend clears;
  - slip_ack pulses on the following cycle.
  - Net effect: the word boundary shifts by one sample.
- Simultaneous slip edge and valid sample: the sample is accepted normally, and the slip applies to the next valid sample (slip_pend is set at the end of that cycle).
- Throughput: with continuous in_valid, one word every RATIO cycles and out_valid spacing exactly RATIO. Each slip stretches one interval to RATIO+1.
- fill_cnt = cnt.
- Assertion requirement: RATIO outside 2..8 is a static elaboration error.

Decomposition:
- Shared package: RATIO_MIN = 2, RATIO_MAX = 8, and a clog2 helper, reused by the divider wrapper and the downstream framer.
- Sub-module slip_ctl: edge detect, pending flag and ack pulse (about 30 lines).
- The gearbox datapath and counter stay in the top.

Test Plan:
- Reset mid-word: DATA_W=2, RATIO=4, MSB_FIRST=1; feed 1,2,3, assert rst_n=0 asynchronously, release, feed 0,1,2,3 -> out_data=8'h1B, out_valid one pulse, the partial word is never emitted.
- Continuous stream: continuous samples 3,2,1,0 repeating -> out_data=8'hE4 every 4 cycles, out_valid period exactly 4, out_valid 1 cycle after the 4th sample.
- Bit order: same stream with MSB_FIRST=0 -> out_data=8'h1B.
- Gapped input: in_valid with 3-cycle gaps between samples -> identical words, out_data held stable between pulses, fill_cnt steps 0,1,2,3.
- Slip: pulse slip once mid-stream -> exactly one sample dropped, slip_ack one pulse, next word shifted by one slot (e.g. 8'h93 after boundary moves), subsequent period back to 4.
- Slip corner cases: slip held high for 10 cycles -> only one drop. Slip rising edge coincident with a valid sample -> that sample is kept and the next one is dropped.
